// File: rtl/core_wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: FSM state encoding and grant source.
package core_wb_arbiter_pkg;

  typedef enum logic [0:0] {
    WB_ARB_NORMAL = 1'b0,
    WB_ARB_FORCE  = 1'b1
  } wb_arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EX   = 2'd1,
    GNT_FIFO = 2'd2,
    GNT_LSU  = 2'd3
  } wb_gnt_e;

endpackage

// File: rtl/core_wb_fifo.sv
// Strictly in-order result buffer for LSU write-backs; synchronous active-high reset.
module core_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter between EX results and buffered LSU loads.
// Optional WB_ARB_STATS_EN adds saturating conflict/force cycle counters.
//
// state  | meaning
// NORMAL | EX has priority, then FIFO head, then LSU fall-through
// FORCE  | one cycle: EX frozen, FIFO head drains
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_we_in,
  input  logic [ADDR_W-1:0] ex_waddr_in,
  input  logic [DATA_W-1:0] ex_wdata_in,
  input  logic              lsu_valid_in,
  output logic              lsu_ready_out,
  input  logic [ADDR_W-1:0] lsu_waddr_in,
  input  logic [DATA_W-1:0] lsu_wdata_in,
  input  logic              pend_set_in,
  input  logic [ADDR_W-1:0] pend_addr_in,
  input  logic [ADDR_W-1:0] rs1_in,
  input  logic [ADDR_W-1:0] rs2_in,
  output logic              hazard_stall_out,
  output logic              ex_stall_out,
  output logic              we_out,
  output logic [ADDR_W-1:0] waddr_out,
  output logic [DATA_W-1:0] wdata_out
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]       stat_conflict_out,
  output logic [31:0]       stat_force_out
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  wb_arb_state_e state_q, state_d;
  wb_gnt_e       gnt;
  logic [SW-1:0] starve_q;
  logic [(2**ADDR_W)-1:0] busy_q;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic ex_req, lsu_xfer, lsu_nz, ex_over_fifo;

  assign ex_req        = ex_we_in && (ex_waddr_in != '0);
  assign lsu_nz        = (lsu_waddr_in != '0);
  assign lsu_ready_out = !fifo_full && !rst;
  assign lsu_xfer      = lsu_valid_in && lsu_ready_out;
  assign {head_addr, head_data} = fifo_dout;
  assign ex_over_fifo  = (gnt == GNT_EX) && !fifo_empty;

  core_wb_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  ({lsu_waddr_in, lsu_wdata_in}),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= WB_ARB_NORMAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = WB_ARB_NORMAL;
    if (state_q == WB_ARB_NORMAL && ex_over_fifo && starve_q == STARVE_LAST)
      state_d = WB_ARB_FORCE;
  end

  // Fall-through only when nothing is buffered, so LSU order is preserved.
  always_comb begin
    gnt          = GNT_NONE;
    ex_stall_out = (state_q == WB_ARB_FORCE);
    if (state_q == WB_ARB_FORCE) gnt = fifo_empty ? GNT_NONE : GNT_FIFO;
    else if (ex_req)             gnt = GNT_EX;
    else if (!fifo_empty)        gnt = GNT_FIFO;
    else if (lsu_xfer && lsu_nz) gnt = GNT_LSU;
    fifo_pop  = (gnt == GNT_FIFO);
    fifo_push = lsu_xfer && lsu_nz && (gnt != GNT_LSU);
  end

  always_ff @(posedge clk) begin
    if (rst)               starve_q <= '0;
    else if (ex_over_fifo) starve_q <= starve_q + 1'b1;
    else                   starve_q <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_out    <= 1'b0;
      waddr_out <= '0;
      wdata_out <= '0;
    end else begin
      case (gnt)
        GNT_EX: begin
          we_out <= 1'b1; waddr_out <= ex_waddr_in; wdata_out <= ex_wdata_in;
        end
        GNT_FIFO: begin
          we_out <= 1'b1; waddr_out <= head_addr; wdata_out <= head_data;
        end
        GNT_LSU: begin
          we_out <= 1'b1; waddr_out <= lsu_waddr_in; wdata_out <= lsu_wdata_in;
        end
        default: we_out <= 1'b0;
      endcase
    end
  end

  // Later assignment wins: a new load to the same register keeps it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (gnt == GNT_FIFO) busy_q[head_addr] <= 1'b0;
      if (gnt == GNT_LSU)  busy_q[lsu_waddr_in] <= 1'b0;
      if (pend_set_in && pend_addr_in != '0) busy_q[pend_addr_in] <= 1'b1;
    end
  end

  assign hazard_stall_out = (rs1_in != '0 && busy_q[rs1_in]) ||
                            (rs2_in != '0 && busy_q[rs2_in]);

  a_ex_not_busy: assert property (@(posedge clk) disable iff (rst)
    (ex_req && state_q == WB_ARB_NORMAL) |-> !busy_q[ex_waddr_in]);

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflict_out <= '0;
      stat_force_out    <= '0;
    end else begin
      if (ex_over_fifo && stat_conflict_out != '1)
        stat_conflict_out <= stat_conflict_out + 1'b1;
      if (state_q == WB_ARB_FORCE && stat_force_out != '1)
        stat_force_out <= stat_force_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Scoreboard bench for core_wb_arbiter: directed scenarios then randomized traffic.
module tb_core_wb_arbiter;
  localparam int AW = 5, DW = 32, DEPTH = 2, SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_we_in = 0, lsu_valid_in = 0, pend_set_in = 0;
  logic [AW-1:0] ex_waddr_in = 0, lsu_waddr_in = 0, pend_addr_in = 0, rs1_in = 0, rs2_in = 0;
  logic [DW-1:0] ex_wdata_in = 0, lsu_wdata_in = 0;
  logic lsu_ready_out, hazard_stall_out, ex_stall_out, we_out;
  logic [AW-1:0] waddr_out;
  logic [DW-1:0] wdata_out;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_conflict_out, stat_force_out;
`endif

  always #5 clk = ~clk;

  core_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .ex_we_in(ex_we_in), .ex_waddr_in(ex_waddr_in), .ex_wdata_in(ex_wdata_in),
    .lsu_valid_in(lsu_valid_in), .lsu_ready_out(lsu_ready_out),
    .lsu_waddr_in(lsu_waddr_in), .lsu_wdata_in(lsu_wdata_in),
    .pend_set_in(pend_set_in), .pend_addr_in(pend_addr_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in),
    .hazard_stall_out(hazard_stall_out), .ex_stall_out(ex_stall_out),
    .we_out(we_out), .waddr_out(waddr_out), .wdata_out(wdata_out)
`ifdef WB_ARB_STATS_EN
    , .stat_conflict_out(stat_conflict_out), .stat_force_out(stat_force_out)
`endif
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t buf_q[$];
  logic [31:0] busy_m = '0;
  bit force_m = 0;
  int starve_m = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every registered write must match the next expected write, in order.
  initial begin
    forever begin
      wr_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_we", we_out, 1'b1);
        chk("wb_addr", waddr_out, e.a);
        chk("wb_data", wdata_out, e.d);
      end else begin
        chk("wb_idle_we", we_out, 1'b0);
      end
    end
  end

  // Reference: LSU results form an ordered queue; EX wins unless a drain is owed.
  task automatic eval();
    bit rdy, ex_req, xfer, fell, clr;
    logic [AW-1:0] ca;
    wr_t w;
    #1;
    rdy = !rst && (buf_q.size() < DEPTH);
    chk("lsu_ready", lsu_ready_out, rdy);
    chk("ex_stall", ex_stall_out, force_m);
    chk("hazard", hazard_stall_out,
        (rs1_in != 0 && busy_m[rs1_in]) || (rs2_in != 0 && busy_m[rs2_in]));
    if (rst) begin
      buf_q.delete();
      busy_m = '0;
      force_m = 0;
      starve_m = 0;
      return;
    end
    ex_req = ex_we_in && ex_waddr_in != 0;
    xfer = lsu_valid_in && rdy;
    fell = 0;
    clr = 0;
    ca = '0;
    if (force_m && buf_q.size() > 0) begin
      w = buf_q.pop_front();
      exp_q.push_back(w);
      clr = 1; ca = w.a;
      force_m = 0; starve_m = 0;
    end else if (force_m) begin
      force_m = 0; starve_m = 0;
    end else if (ex_req) begin
      exp_q.push_back('{a: ex_waddr_in, d: ex_wdata_in});
      if (buf_q.size() > 0) begin
        if (starve_m == SMAX - 1) force_m = 1;
        starve_m++;
      end else starve_m = 0;
    end else if (buf_q.size() > 0) begin
      w = buf_q.pop_front();
      exp_q.push_back(w);
      clr = 1; ca = w.a;
      starve_m = 0;
    end else begin
      starve_m = 0;
      if (xfer && lsu_waddr_in != 0) begin
        exp_q.push_back('{a: lsu_waddr_in, d: lsu_wdata_in});
        fell = 1; clr = 1; ca = lsu_waddr_in;
      end
    end
    if (xfer && !fell && lsu_waddr_in != 0)
      buf_q.push_back('{a: lsu_waddr_in, d: lsu_wdata_in});
    if (clr) busy_m[ca] = 1'b0;
    if (pend_set_in && pend_addr_in != 0) busy_m[pend_addr_in] = 1'b1;
  endtask

  task automatic drive(input logic r, input logic ew, input logic [AW-1:0] ea,
                       input logic [DW-1:0] ed, input logic lv, input logic [AW-1:0] la,
                       input logic [DW-1:0] ld, input logic ps, input logic [AW-1:0] pa,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    @(negedge clk);
    rst = r; ex_we_in = ew; ex_waddr_in = ea; ex_wdata_in = ed;
    lsu_valid_in = lv; lsu_waddr_in = la; lsu_wdata_in = ld;
    pend_set_in = ps; pend_addr_in = pa; rs1_in = r1; rs2_in = r2;
    eval();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_we", we_out, 1'b0);
    chk("rst_waddr", waddr_out, 0);
    chk("rst_wdata", wdata_out, 0);
    // EX only, LSU fall-through, simultaneous conflict
    drive(0, 1, 5, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 7, 32'hAB, 0, 0, 0, 0);
    drive(0, 1, 9, 32'h22, 1, 10, 32'h33, 0, 0, 0, 0);
    idle(2);
    // Starvation: EX every cycle while LSU keeps the buffer full
    for (int i = 0; i < 8; i++)
      drive(0, 1, AW'(1 + i), DW'(32'h100 + i), 1, AW'(20 + i), DW'(32'h200 + i), 0, 0, 0, 0);
    idle(4);
    // Scoreboard: pending x3 stalls ID until its load is written; x0 never pends
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
    drive(0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    drive(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0, 0, 0);
    // Reset with buffered results and a pending register
    drive(0, 1, 4, 32'h44, 1, 18, 32'h55, 1, 18, 0, 0);
    drive(0, 1, 6, 32'h66, 1, 19, 32'h77, 0, 0, 18, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 18, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 18, 0);
    chk("post_rst_we", we_out, 1'b0);
    idle(2);
    // Randomized traffic; EX held stable whenever a forced drain is due
    for (int i = 0; i < 3000; i++) begin
      logic ew; logic [AW-1:0] ea; logic [DW-1:0] ed;
      if (force_m) begin
        ew = ex_we_in; ea = ex_waddr_in; ed = ex_wdata_in;
      end else begin
        ew = ($urandom_range(0, 9) < 6);
        ea = AW'($urandom_range(0, 15));
        ed = $urandom;
      end
      drive(($urandom_range(0, 199) == 0), ew, ea, ed,
            ($urandom_range(0, 9) < 4), AW'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(16, 31)),
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    end
    idle(6);
    chk("drain_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
